ooo_commit_unit: RTL and testbench
==================================

# ooo_commit_unit

In-order retirement stage that consumes the OoO engine's commit stream (`ooo_commit_t` with a valid/ready handshake) and performs the architectural side effects. For each retired instruction it writes the architectural register file, counts retirements and reports the retired PC. Branch mispredictions become a flush plus PC redirect; exceptions become a flush plus trap request. It sits between the engine's commit output and the architectural register file / trap logic, and owns the engine's `flush_i`.

## Interface
- `DATA_WIDTH`, 32, result / register data width
- `PC_WIDTH`, 32, PC width
- `REG_ADDR_WIDTH`, 5, architectural register index width
- `CAUSE_WIDTH`, 4, exception cause width
- `FLUSH_CYCLES`, 2, cycles the unit stays blocked after any flush; minimum 1
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `commit_i`  in  `ooo_commit_t`  commit entry; fields used: `valid`, `pc`, `rd_addr`, `rd_write_en`, `result`, `exception`, `exc_cause`, `mispredict`, `target_pc`
- `commit_ready_o`  out  1  unit accepts a commit this cycle
- `rf_we_o`  out  1  architectural register write enable
- `rf_waddr_o`  out  REG_ADDR_WIDTH  write address
- `rf_wdata_o`  out  DATA_WIDTH  write data
- `retire_valid_o`  out  1  one-cycle pulse per retired instruction
- `retire_pc_o`  out  PC_WIDTH  PC of retired instruction
- `flush_o`  out  1  one-cycle flush pulse to the OoO engine
- `redirect_valid_o`  out  1  fetch redirect pulse
- `redirect_pc_o`  out  PC_WIDTH  redirect target
- `trap_valid_o`  out  1  trap request, level-held until acknowledged
- `trap_epc_o`  out  PC_WIDTH  faulting PC
- `trap_cause_o`  out  CAUSE_WIDTH  cause
- `trap_ack_i`  in  1  trap handler has taken the trap
- `instret_o`  out  64  retired-instruction counter

## Operation
- FSM `commit_state_e` has three states: `RUN`, `FLUSH`, `TRAP`. Reset enters `RUN`.
- `commit_ready_o = (state == RUN)`. It depends on state only and never on `commit_i.valid`.
- Handshake: fire = `commit_i.valid && commit_ready_o`. Without fire, no output pulses and no counter change.
- **Normal fire** (no exception, no mispredict):
  - If `rd_write_en && rd_addr != 0`, write the register. A write to x0 is suppressed: `rf_we_o` stays 0.
  - Pulse `retire_valid_o` and `retire_pc_o = pc`.
  - `instret_o += 1`.
- **Mispredict fire**:
  - Perform the normal retirement: rd write, retire pulse, counter increment.
  - Pulse `flush_o` and `redirect_valid_o`, with `redirect_pc_o = target_pc`.
  - Next state `FLUSH`, with down-counter loaded to `FLUSH_CYCLES-1`.
- **Exception fire** (wins over mispredict if both are set):
  - No rd write, no retire pulse, no counter increment.
  - Pulse `flush_o`.
  - Set `trap_valid_o`, `trap_epc_o = pc`, `trap_cause_o = exc_cause`.
  - Next state `TRAP`.
- `FLUSH` state: decrement the counter; at 0, go to `RUN`.
- `TRAP` state: hold `trap_valid_o` and its payload. On `trap_ack_i`, clear `trap_valid_o` and go to `FLUSH` with the counter loaded to `FLUSH_CYCLES-1`. `trap_ack_i` outside `TRAP` is ignored.
- `instret_o` wraps from 2^64-1 to 0.
- Reset values:
  - All outputs 0 except `commit_ready_o = 1`.
  - `instret_o = 0`, state `RUN`.
  - A reset during `FLUSH` or `TRAP` aborts it immediately. No flush, trap or redirect is issued after reset.

## Timing
- All outputs are registered except `commit_ready_o`, which is combinational from state.
- A fire at edge N produces `rf_*`, `retire_*`, `flush_o`, `redirect_*`, `trap_*` and the updated `instret_o` during cycle N+1.
- `flush_o` and `redirect_valid_o` are high for exactly one cycle per event.
- After a mispredict fire at N:
  - `commit_ready_o` is low for cycles N+1 … N+FLUSH_CYCLES.
  - It is high again at N+FLUSH_CYCLES+1.
- After `trap_ack_i` sampled at edge M:
  - `trap_valid_o` is 0 in cycle M+1.
  - `commit_ready_o` is low for FLUSH_CYCLES cycles starting M+1, then high.
- Throughput: one retirement per cycle with no bubbles while in `RUN`.

## Structure
- `ooo_pkg` gains:
  - `commit_state_e`.
  - `CAUSE_WIDTH`.
  - The `exception`, `exc_cause`, `mispredict` and `target_pc` fields of `ooo_commit_t`.
- Single module, no sub-module: the flush down-counter and the 64-bit counter are inline.

## Test plan
- **Back-to-back retirement:** 4 consecutive commits to x1..x4 with data 0x11..0x44 → four consecutive `rf_we_o` pulses, `instret_o` = 4, `commit_ready_o` stays 1.
- **x0 write suppression:** commit with `rd_addr=0`, `rd_write_en=1` → `rf_we_o = 0`, `retire_valid_o = 1`, `instret_o` +1.
- **Mispredict:** commit with `mispredict=1`, `target_pc=0x200`, `FLUSH_CYCLES=2` → next cycle has `flush_o`, `redirect_valid_o` and `redirect_pc_o=0x200`; ready low for 2 cycles; a commit held valid is accepted only at the 3rd cycle.
- **Exception (also covers exception priority):** commit with `exception=1`, `mispredict=1`, `exc_cause=2`, `pc=0x80` → `flush_o` pulse, no redirect, `trap_valid_o=1` with `trap_epc_o=0x80` and `trap_cause_o=2`, no rd write, `instret_o` unchanged. Hold 5 cycles, then `trap_ack_i` → `trap_valid_o` drops and ready returns after FLUSH_CYCLES.
- **Reset mid-operation:** `rst_i` asserted during `FLUSH` and during `TRAP` → next cycle all outputs 0, `commit_ready_o=1`, `instret_o=0`.
- **Counter wrap:** preload/force `instret_o = 2^64-1`, one retirement → `instret_o = 0`.

Source files
------------

// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared types for the OoO engine commit path
package ooo_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int PC_WIDTH       = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int CAUSE_WIDTH    = 4;

    // Retirement FSM: normal flow, post-flush drain, waiting for trap handler
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } commit_state_e;

    // One entry of the engine's in-order commit stream
    typedef struct packed {
        logic                      valid;
        logic [PC_WIDTH-1:0]       pc;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      rd_write_en;
        logic [DATA_WIDTH-1:0]     result;
        logic                      exception;
        logic [CAUSE_WIDTH-1:0]    exc_cause;
        logic                      mispredict;
        logic [PC_WIDTH-1:0]       target_pc;
    } ooo_commit_t;

endpackage

// File: rtl/ooo_commit_unit.sv
// rtl/ooo_commit_unit.sv - in-order retirement: regfile write, instret, flush/redirect, trap request
module ooo_commit_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CAUSE_WIDTH    = 4,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  ooo_pkg::ooo_commit_t      commit_i,
    output logic                      commit_ready_o,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      retire_valid_o,
    output logic [PC_WIDTH-1:0]       retire_pc_o,
    output logic                      flush_o,
    output logic                      redirect_valid_o,
    output logic [PC_WIDTH-1:0]       redirect_pc_o,
    output logic                      trap_valid_o,
    output logic [PC_WIDTH-1:0]       trap_epc_o,
    output logic [CAUSE_WIDTH-1:0]    trap_cause_o,
    input  logic                      trap_ack_i,
    output logic [63:0]               instret_o
);

    // Down-counter only needs to hold FLUSH_CYCLES-1
    localparam int               CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    ooo_pkg::commit_state_e    r_state;
    ooo_pkg::commit_state_e    w_state_next;
    logic                      w_cnt_load;
    logic [CNT_W-1:0]          r_flush_cnt;

    logic                      w_fire;
    logic                      w_exc;
    logic                      w_mis;
    logic                      w_retire;

    logic                      r_rf_we;
    logic [REG_ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0]     r_rf_wdata;
    logic                      r_retire_valid;
    logic [PC_WIDTH-1:0]       r_retire_pc;
    logic                      r_flush;
    logic                      r_redirect_valid;
    logic [PC_WIDTH-1:0]       r_redirect_pc;
    logic                      r_trap_valid;
    logic [PC_WIDTH-1:0]       r_trap_epc;
    logic [CAUSE_WIDTH-1:0]    r_trap_cause;
    logic [63:0]               r_instret;

    // Exception beats mispredict; a faulting instruction never retires
    assign commit_ready_o = (r_state == ooo_pkg::RUN);
    assign w_fire         = commit_i.valid && commit_ready_o;
    assign w_exc          = w_fire && commit_i.exception;
    assign w_mis          = w_fire && !commit_i.exception && commit_i.mispredict;
    assign w_retire       = w_fire && !commit_i.exception;

    // Next-state selection and flush counter reload requests
    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        case (r_state)
            ooo_pkg::RUN: begin
                if (w_exc) begin
                    w_state_next = ooo_pkg::TRAP;
                end else if (w_mis) begin
                    w_state_next = ooo_pkg::FLUSH;
                    w_cnt_load   = 1'b1;
                end
            end
            ooo_pkg::FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_state_next = ooo_pkg::RUN;
                end
            end
            ooo_pkg::TRAP: begin
                if (trap_ack_i) begin
                    w_state_next = ooo_pkg::FLUSH;
                    w_cnt_load   = 1'b1;
                end
            end
            default: w_state_next = ooo_pkg::RUN;
        endcase
    end

    // State register and flush drain counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ooo_pkg::RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cnt_load) begin
                r_flush_cnt <= CNT_LOAD;
            end else if (r_state == ooo_pkg::FLUSH && r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
        end
    end

    // Registered side effects of each accepted commit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rf_we          <= 1'b0;
            r_rf_waddr       <= '0;
            r_rf_wdata       <= '0;
            r_retire_valid   <= 1'b0;
            r_retire_pc      <= '0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_trap_valid     <= 1'b0;
            r_trap_epc       <= '0;
            r_trap_cause     <= '0;
            r_instret        <= '0;
        end else begin
            r_rf_we          <= w_retire && commit_i.rd_write_en && (commit_i.rd_addr != '0);
            r_retire_valid   <= w_retire;
            r_flush          <= w_exc || w_mis;
            r_redirect_valid <= w_mis;
            if (w_retire) begin
                r_rf_waddr  <= REG_ADDR_WIDTH'(commit_i.rd_addr);
                r_rf_wdata  <= DATA_WIDTH'(commit_i.result);
                r_retire_pc <= PC_WIDTH'(commit_i.pc);
                r_instret   <= r_instret + 64'd1;
            end
            if (w_mis) begin
                r_redirect_pc <= PC_WIDTH'(commit_i.target_pc);
            end
            if (w_exc) begin
                r_trap_valid <= 1'b1;
                r_trap_epc   <= PC_WIDTH'(commit_i.pc);
                r_trap_cause <= CAUSE_WIDTH'(commit_i.exc_cause);
            end else if (r_state == ooo_pkg::TRAP && trap_ack_i) begin
                r_trap_valid <= 1'b0;
            end
        end
    end

    assign rf_we_o          = r_rf_we;
    assign rf_waddr_o       = r_rf_waddr;
    assign rf_wdata_o       = r_rf_wdata;
    assign retire_valid_o   = r_retire_valid;
    assign retire_pc_o      = r_retire_pc;
    assign flush_o          = r_flush;
    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;
    assign trap_valid_o     = r_trap_valid;
    assign trap_epc_o       = r_trap_epc;
    assign trap_cause_o     = r_trap_cause;
    assign instret_o        = r_instret;

endmodule

// File: tb/tb_ooo_commit_unit.sv
// tb/tb_ooo_commit_unit.sv - self-checking bench for ooo_commit_unit
module tb_ooo_commit_unit;
    import ooo_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    ooo_commit_t commit;
    logic        trap_ack;
    logic        commit_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_epc;
    logic [3:0]  trap_cause;
    logic [63:0] instret;

    ooo_commit_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk_i(clk), .rst_i(rst), .commit_i(commit), .commit_ready_o(commit_ready),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .retire_valid_o(retire_valid), .retire_pc_o(retire_pc), .flush_o(flush),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .trap_valid_o(trap_valid), .trap_epc_o(trap_epc), .trap_cause_o(trap_cause),
        .trap_ack_i(trap_ack), .instret_o(instret)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] m_instret;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        exc;
        logic [3:0]  cause;
        logic        mis;
        logic [31:0] tgt;
        logic        e_we;
        logic        e_ret;
        logic        e_flush;
        logic        e_redir;
        logic        e_trap;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        commit   = '0;
        trap_ack = 1'b0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                         input logic [31:0] data, input logic exc, input logic [3:0] cause,
                         input logic mis, input logic [31:0] tgt);
        commit.valid       = 1'b1;
        commit.pc          = pc;
        commit.rd_addr     = rd;
        commit.rd_write_en = we;
        commit.result      = data;
        commit.exception   = exc;
        commit.exc_cause   = cause;
        commit.mispredict  = mis;
        commit.target_pc   = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_instret = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},   commit_ready, 1);
        check({tag, "_rf_we"},   rf_we, 0);
        check({tag, "_waddr"},   rf_waddr, 0);
        check({tag, "_wdata"},   rf_wdata, 0);
        check({tag, "_retire"},  retire_valid, 0);
        check({tag, "_rpc"},     retire_pc, 0);
        check({tag, "_flush"},   flush, 0);
        check({tag, "_redir"},   redirect_valid, 0);
        check({tag, "_redirpc"}, redirect_pc, 0);
        check({tag, "_trap"},    trap_valid, 0);
        check({tag, "_epc"},     trap_epc, 0);
        check({tag, "_cause"},   trap_cause, 0);
        check({tag, "_instret"}, instret, 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!commit_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready_return"}, commit_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        do_reset();
        check_reset_state("reset");

        // Single-commit vectors from RUN
        vecs[0] = '{1, 32'h100, 5'd5, 1, 32'hDEAD, 0, 4'd0, 0, 32'h0,     1, 1, 0, 0, 0};
        vecs[1] = '{1, 32'h104, 5'd6, 0, 32'h1234, 0, 4'd0, 0, 32'h0,     0, 1, 0, 0, 0};
        vecs[2] = '{1, 32'h108, 5'd0, 1, 32'h5555, 0, 4'd0, 0, 32'h0,     0, 1, 0, 0, 0};
        vecs[3] = '{0, 32'h10C, 5'd7, 1, 32'h7777, 0, 4'd0, 0, 32'h0,     0, 0, 0, 0, 0};
        vecs[4] = '{1, 32'h110, 5'd8, 1, 32'h8888, 0, 4'd0, 1, 32'h400,   1, 1, 1, 1, 0};
        vecs[5] = '{1, 32'h114, 5'd9, 1, 32'h9999, 1, 4'd7, 0, 32'h0,     0, 0, 1, 0, 1};
        vecs[6] = '{1, 32'h118, 5'd3, 1, 32'h3333, 1, 4'd5, 1, 32'h500,   0, 0, 1, 0, 1};
        vecs[7] = '{1, 32'h11C, 5'd0, 1, 32'hAAAA, 0, 4'd0, 1, 32'h600,   0, 1, 1, 1, 0};

        for (int i = 0; i < 8; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            check({t, "_ready_pre"}, commit_ready, 1);
            if (vecs[i].valid)
                drive(vecs[i].pc, vecs[i].rd, vecs[i].we, vecs[i].data, vecs[i].exc,
                      vecs[i].cause, vecs[i].mis, vecs[i].tgt);
            else begin
                commit = '0;
                commit.pc = vecs[i].pc;
            end
            step();
            idle();
            check({t, "_rf_we"},  rf_we, vecs[i].e_we);
            check({t, "_retire"}, retire_valid, vecs[i].e_ret);
            check({t, "_flush"},  flush, vecs[i].e_flush);
            check({t, "_redir"},  redirect_valid, vecs[i].e_redir);
            check({t, "_trap"},   trap_valid, vecs[i].e_trap);
            if (vecs[i].e_we) begin
                check({t, "_waddr"}, rf_waddr, vecs[i].rd);
                check({t, "_wdata"}, rf_wdata, vecs[i].data);
            end
            if (vecs[i].e_ret)   check({t, "_rpc"}, retire_pc, vecs[i].pc);
            if (vecs[i].e_redir) check({t, "_redirpc"}, redirect_pc, vecs[i].tgt);
            if (vecs[i].e_trap) begin
                check({t, "_epc"}, trap_epc, vecs[i].pc);
                check({t, "_cause"}, trap_cause, vecs[i].cause);
            end
            if (vecs[i].e_ret) m_instret = m_instret + 1;
            check({t, "_instret"}, instret, m_instret);
            if (vecs[i].e_trap) begin
                trap_ack = 1'b1;
                step();
                trap_ack = 1'b0;
            end
            wait_ready(t);
        end

        // Back-to-back retirement
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(32'h1000 + 32'(4 * i), 5'(i), 1'b1, 32'(8'h11 * i), 1'b0, 4'd0, 1'b0, 32'd0);
            check($sformatf("b2b%0d_ready", i), commit_ready, 1);
            step();
            check($sformatf("b2b%0d_we", i), rf_we, 1);
            check($sformatf("b2b%0d_waddr", i), rf_waddr, i);
            check($sformatf("b2b%0d_wdata", i), rf_wdata, 8'h11 * i);
        end
        idle();
        check("b2b_instret", instret, 4);
        check("b2b_ready_after", commit_ready, 1);

        // Mispredict with a commit held valid through the flush window
        drive(32'h300, 5'd2, 1'b1, 32'h22, 1'b0, 4'd0, 1'b1, 32'h200);
        step();
        check("mis_flush", flush, 1);
        check("mis_redir", redirect_valid, 1);
        check("mis_redirpc", redirect_pc, 32'h200);
        check("mis_instret", instret, 5);
        check("mis_ready_c1", commit_ready, 0);
        drive(32'h304, 5'd7, 1'b1, 32'h77, 1'b0, 4'd0, 1'b0, 32'd0);
        step();
        check("mis_ready_c2", commit_ready, 0);
        check("mis_flush_once", flush, 0);
        check("mis_redir_once", redirect_valid, 0);
        check("mis_no_accept_c1", retire_valid, 0);
        step();
        check("mis_ready_c3", commit_ready, 1);
        check("mis_no_accept_c2", rf_we, 0);
        step();
        idle();
        check("mis_held_we", rf_we, 1);
        check("mis_held_waddr", rf_waddr, 7);
        check("mis_held_instret", instret, 6);

        // Exception with mispredict also set
        drive(32'h80, 5'd4, 1'b1, 32'h44, 1'b1, 4'd2, 1'b1, 32'h900);
        step();
        idle();
        check("exc_flush", flush, 1);
        check("exc_no_redir", redirect_valid, 0);
        check("exc_trap", trap_valid, 1);
        check("exc_epc", trap_epc, 32'h80);
        check("exc_cause", trap_cause, 2);
        check("exc_no_we", rf_we, 0);
        check("exc_no_retire", retire_valid, 0);
        check("exc_instret", instret, 6);
        for (int i = 0; i < 5; i++) begin
            drive(32'h84, 5'd1, 1'b1, 32'h1, 1'b0, 4'd0, 1'b0, 32'd0);
            step();
            check($sformatf("exc_hold%0d_trap", i), trap_valid, 1);
            check($sformatf("exc_hold%0d_ready", i), commit_ready, 0);
            check($sformatf("exc_hold%0d_flush", i), flush, 0);
            check($sformatf("exc_hold%0d_noret", i), retire_valid, 0);
        end
        idle();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("ack_trap_clear", trap_valid, 0);
        check("ack_ready_c1", commit_ready, 0);
        step();
        check("ack_ready_c2", commit_ready, 0);
        step();
        check("ack_ready_c3", commit_ready, 1);

        // Reset during FLUSH
        drive(32'h40, 5'd1, 1'b1, 32'h1, 1'b0, 4'd0, 1'b1, 32'h44);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst_flush");

        // Reset during TRAP
        drive(32'h50, 5'd1, 1'b1, 32'h1, 1'b1, 4'd3, 1'b0, 32'h0);
        step();
        idle();
        step();
        check("rst_trap_pre", trap_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst_trap");
        step();
        check("rst_trap_after_flush", flush, 0);
        check("rst_trap_after_trap", trap_valid, 0);
        check("rst_trap_after_ready", commit_ready, 1);

        // instret wrap
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        check("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(32'h60, 5'd1, 1'b1, 32'h1, 1'b0, 4'd0, 1'b0, 32'h0);
        step();
        idle();
        check("wrap_instret", instret, 0);

        // Randomised stream against a counting model
        do_reset();
        begin
            int          blocked = 0;
            bit          in_trap = 0;
            logic [31:0] m_epc   = '0;
            logic [3:0]  m_cause = '0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                bit          ready_m, fire, e_we, e_ret, e_flush, e_redir;
                logic        r_exc, r_mis, r_we;
                logic [4:0]  r_rd;
                logic [31:0] r_pc, r_data, r_tgt;
                logic [3:0]  r_cause;
                r_pc    = $urandom;
                r_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                r_we    = ($urandom_range(0, 3) != 0);
                r_data  = $urandom;
                r_exc   = ($urandom_range(0, 15) == 0);
                r_cause = 4'($urandom);
                r_mis   = ($urandom_range(0, 7) == 0);
                r_tgt   = $urandom;
                if ($urandom_range(0, 3) != 0)
                    drive(r_pc, r_rd, r_we, r_data, r_exc, r_cause, r_mis, r_tgt);
                else
                    commit = '0;
                trap_ack = in_trap ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);

                ready_m = !in_trap && blocked == 0;
                check("rnd_ready", commit_ready, ready_m);
                fire    = commit.valid && ready_m;
                e_ret   = fire && !r_exc;
                e_we    = e_ret && r_we && r_rd != 0;
                e_flush = fire && (r_exc || r_mis);
                e_redir = e_ret && r_mis;

                step();

                if (in_trap) begin
                    if (trap_ack) begin
                        in_trap = 0;
                        blocked = FC;
                    end
                end else if (blocked > 0) begin
                    blocked--;
                end
                if (fire && r_exc) begin
                    in_trap = 1;
                    m_epc   = r_pc;
                    m_cause = r_cause;
                end else if (e_redir) begin
                    blocked = FC;
                end
                if (e_ret) m_instret = m_instret + 1;

                check("rnd_we", rf_we, e_we);
                check("rnd_retire", retire_valid, e_ret);
                check("rnd_flush", flush, e_flush);
                check("rnd_redir", redirect_valid, e_redir);
                check("rnd_trap", trap_valid, in_trap);
                check("rnd_instret", instret, m_instret);
                if (e_we) begin
                    check("rnd_waddr", rf_waddr, r_rd);
                    check("rnd_wdata", rf_wdata, r_data);
                end
                if (e_ret)   check("rnd_rpc", retire_pc, r_pc);
                if (e_redir) check("rnd_redirpc", redirect_pc, r_tgt);
                if (in_trap) begin
                    check("rnd_epc", trap_epc, m_epc);
                    check("rnd_cause", trap_cause, m_cause);
                end
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
